spi_mnrch_param: RTL and testbench
==================================

# spi_mnrch_param

Parametrised SPI monarch (master) that generalises the team's fixed 16-bit, mode-3 SPI monarch. It adds configurable word width, SCLK divide ratio, multiple serf selects, and per-transfer CPOL/CPHA mode. It sits between on-chip control logic (inertial sensor, A2D, and similar peripheral drivers) and the off-chip SPI pins. Each transfer is full-duplex, MSB first, and started by a single-cycle `wrt` request.

## Interface
- `DATA_W`, default 16: bits per transfer; must be ≥ 2.
- `SCLK_DIV`, default 16: clk cycles per SCLK period; must be even and ≥ 4. H = SCLK_DIV/2.
- `NUM_SS`, default 1: number of serf-select lines. SEL_W = max(1, $clog2(NUM_SS)).

- `clk` in 1: system clock. The only clock in the block.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `wrt` in 1: start request. Honoured only when `busy` = 0.
- `wt_data` in DATA_W: word to transmit. Latched on accept.
- `ss_sel` in SEL_W: index of the serf to select. Latched on accept.
- `cpol` in 1: SCLK idle level. Latched on accept.
- `cpha` in 1: 0 means sample on the leading edge; 1 means sample on the trailing edge. Latched on accept.
- `MISO` in 1: serial data from the serf.
- `SCLK` out 1: serial clock.
- `MOSI` out 1: serial data to the serf.
- `SS_n` out NUM_SS: active-low selects. At most one bit is low at any time.
- `busy` out 1: high from the cycle after accept through the back porch.
- `done` out 1: set on completion. Cleared on the next accept.
- `rd_data` out DATA_W: received word. Valid while `done` = 1.

## Operation
- **States:** IDLE → FRONT → XFER → BACK → IDLE.
- **IDLE:**
  - SCLK = latched `cpol`. All SS_n bits are high.
  - `wrt` = 1 is an accept. On accept: latch `wt_data`, `ss_sel`, `cpol` and `cpha`; clear `done`; go to FRONT.
- **FRONT:**
  - SS_n[sel] is low. SCLK stays at the idle level for H clks.
  - MOSI presents `wt_data[DATA_W-1]`.
- **XFER:**
  - SCLK toggles every H clks, producing 2·DATA_W edges. The leading edge leaves the idle level; the trailing edge returns to it.
  - CPHA=0: sample on leading edges. MOSI changes on trailing edges, except the final trailing edge, where MOSI holds.
  - CPHA=1: the first leading edge does not shift MOSI, since the MSB is already presented. Subsequent leading edges advance MOSI to the next bit. Sample on trailing edges.
  - MISO is captured on the clk edge at which SCLK takes its new level. The k-th sampled bit becomes `rd_data[DATA_W-1-k]`.
- **BACK:**
  - SCLK stays at the idle level for H clks after the last edge.
  - Then SS_n goes high, `done` = 1, `busy` = 0, and the block returns to IDLE.
- **Ignored requests:** `wrt` during FRONT, XFER or BACK is ignored. It is not queued.
- **Back-to-back:** `wrt` in the cycle where `done` rises is accepted. SS_n is then high for exactly 1 clk between words.
- **Out-of-range select:** `ss_sel` ≥ NUM_SS on accept runs the full transfer with all SS_n bits held high. `rd_data` receives whatever is on MISO.
- **Mid-transfer changes:** changes on `cpol`, `cpha`, `ss_sel` or `wt_data` during a transfer have no effect on it.
- **Reset values:**
  - State = IDLE; `busy` = 0; `done` = 0; `rd_data` = 0; MOSI = 0; all SS_n = 1.
  - Latched cpol = 1, so SCLK = 1 (legacy mode 3); latched cpha = 1.
- **Reset mid-transfer:** all outputs return to their reset values asynchronously. No partial `done` is produced.

## Timing
- **Accept edge = cycle 0.** From cycle 1: SS_n[sel] low, `busy` = 1.
- **First leading SCLK edge:** cycle 1+H.
- **Edge k (k = 1..2·DATA_W):** at cycle 1+k·H.
- **Completion:** SS_n high, `done` = 1 and `busy` = 0 at cycle 1+(2·DATA_W+1)·H.
  - Defaults: 1 + 33·8 = cycle 265.
- **MOSI settle time:** MOSI changes only on drive edges, giving ≥ H clks of setup before each sample edge.
- **Data lifetime:** `rd_data` and `done` hold until the next accept.

## Test plan
- **Default mode 3:**
  - Stimulus: defaults, `wt_data` = 0xA5C3, serf echoes 0x3C5A.
  - Required: MOSI bit stream 0xA5C3 MSB first; `rd_data` = 0x3C5A; `done` rises at cycle 265; SCLK idle high; 16 falling/rising pairs.
- **Mode sweep:**
  - Stimulus: all 4 cpol/cpha combinations with `wt_data` = 0x8001, serf model checks the mode.
  - Required: every bit is sampled on the correct edge; SCLK idle level equals `cpol` before and after the transfer.
- **Alternate parameters:**
  - Stimulus: DATA_W=8, SCLK_DIV=4, NUM_SS=4, `ss_sel` = 2, `wt_data` = 0x5A.
  - Required: only SS_n[2] goes low; `done` at cycle 1+17·2 = 35; `rd_data` equals the serf word.
- **Back-to-back and ignored requests:**
  - Stimulus: `wrt` pulsed mid-transfer, then `wrt` held high continuously.
  - Required: the mid-transfer pulse is ignored (one transfer only); with `wrt` held, SS_n is high for exactly 1 clk between words; `done` clears on the accept.
- **Reset mid-transfer:**
  - Stimulus: `rst_n` asserted at cycle 100.
  - Required: SS_n = all 1, SCLK = 1, `busy` = 0, `done` = 0 immediately (asynchronously); the next `wrt` completes normally.

Source files
------------

// File: rtl/spi_mnrch_param.sv
// Parameterised SPI monarch: DATA_W-bit full-duplex MSB-first transfers,
// SCLK = clk/SCLK_DIV, NUM_SS active-low selects, CPOL/CPHA latched per
// transfer. Sequence is IDLE -> FRONT -> XFER -> BACK -> IDLE; FRONT and
// BACK hold SCLK at its idle level for half an SCLK period around the
// 2*DATA_W SCLK edges.
module spi_mnrch_param #(
    parameter int  DATA_W   = 16,
    parameter int  SCLK_DIV = 16,
    parameter int  NUM_SS   = 1,
    localparam int SEL_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt,
    input  logic [DATA_W-1:0] wt_data,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI,
    output logic [NUM_SS-1:0] SS_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data
);

    localparam int H         = SCLK_DIV / 2;
    localparam int CNT_W     = (H > 1) ? $clog2(H) : 1;
    localparam int LAST_EDGE = 2 * DATA_W;
    localparam int EDGE_W    = $clog2(LAST_EDGE + 1);

    typedef enum logic [1:0] {IDLE, FRONT, XFER, BACK} state_t;

    // Per-transfer SPI mode, captured on accept.
    typedef struct packed {
        logic cpol;
        logic cpha;
    } mode_t;

    state_t            state, nxt;
    mode_t             mode_q;
    logic [CNT_W-1:0]  cnt;
    logic [EDGE_W-1:0] edge_cnt, edge_num;
    logic              sclk_q;
    logic [DATA_W-1:0] tx_sr, rx_sr;
    logic [NUM_SS-1:0] ss_q, sel_dec;
    logic              accept, half_done, do_edge, leading, last_edge;
    logic              sample, shift, finish;

    // One-hot decode of the requested serf; an out-of-range index decodes
    // to all zeros, so every select stays high for that transfer.
    for (genvar i = 0; i < NUM_SS; i++) begin : g_sel
        assign sel_dec[i] = (ss_sel == SEL_W'(i));
    end

    assign SCLK = sclk_q;
    assign MOSI = tx_sr[DATA_W-1];
    assign SS_n = ss_q;

    // Strobes: edge k fires at the end of each H-clk window; odd edges are
    // leading. CPHA=0 samples leading / shifts trailing (not the last one);
    // CPHA=1 samples trailing / shifts leading (not the first one).
    always_comb begin
        accept    = (state == IDLE) && wrt;
        half_done = (cnt == CNT_W'(H - 1));
        edge_num  = edge_cnt + EDGE_W'(1);
        leading   = edge_num[0];
        last_edge = (edge_num == EDGE_W'(LAST_EDGE));
        do_edge   = ((state == FRONT) || (state == XFER)) && half_done;
        sample    = do_edge && (leading ^ mode_q.cpha);
        shift     = do_edge && (mode_q.cpha ? (leading && (edge_num != EDGE_W'(1)))
                                            : (!leading && !last_edge));
        finish    = (state == BACK) && half_done;
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (wrt) nxt = FRONT;
            FRONT:   if (half_done) nxt = XFER;
            XFER:    if (half_done && last_edge) nxt = BACK;
            BACK:    if (half_done) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Half-period timer and SCLK edge counter; both park at zero in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            edge_cnt <= '0;
        end else if (state == IDLE) begin
            cnt      <= '0;
            edge_cnt <= '0;
        end else begin
            cnt <= half_done ? '0 : cnt + CNT_W'(1);
            if (do_edge) edge_cnt <= edge_num;
        end
    end

    // Mode latch, SCLK, selects and handshake flags. Reset idles in mode 3
    // so the legacy fixed-mode peripherals see a high SCLK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '{cpol: 1'b1, cpha: 1'b1};
            sclk_q <= 1'b1;
            ss_q   <= '1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (accept) begin
            mode_q <= '{cpol: cpol, cpha: cpha};
            sclk_q <= cpol;
            ss_q   <= ~sel_dec;
            busy   <= 1'b1;
            done   <= 1'b0;
        end else if (do_edge) begin
            sclk_q <= ~sclk_q;
        end else if (finish) begin
            ss_q <= '1;
            busy <= 1'b0;
            done <= 1'b1;
        end
    end

    // Shift registers. MISO is sampled on the clk edge that moves SCLK, so
    // it sees the value the serf set up half an SCLK period earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            rd_data <= '0;
        end else begin
            if (accept)     tx_sr <= wt_data;
            else if (shift) tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            if (sample)     rx_sr <= {rx_sr[DATA_W-2:0], MISO};
            if (finish)     rd_data <= rx_sr;
        end
    end

endmodule

// File: tb/tb_spi_mnrch_param.sv
// Bench for spi_mnrch_param: a default instance (16b, /16, 1 select) and an
// alternate one (8b, /4, 4 selects) share a behavioural serf. Expected
// words and completion cycles go into a scoreboard on accept and are
// checked when done rises.
module tb_spi_mnrch_param;

    localparam int D0 = 16, H0 = 8, D1 = 8, H1 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // default instance
    logic        wrt0, cpol0, cpha0, sclk0, mosi0, busy0, done0;
    logic [15:0] wd0, rd0;
    logic [0:0]  sel0, ss0;
    // alternate instance
    logic        wrt1, cpol1, cpha1, sclk1, mosi1, busy1, done1;
    logic [7:0]  wd1, rd1;
    logic [1:0]  sel1;
    logic [3:0]  ss1;
    // shared MISO, optionally forced to a constant
    logic        miso, serf_miso, force_en, force_val;
    assign miso = force_en ? force_val : serf_miso;

    spi_mnrch_param dut0 (
        .clk(clk), .rst_n(rst_n), .wrt(wrt0), .wt_data(wd0), .ss_sel(sel0),
        .cpol(cpol0), .cpha(cpha0), .MISO(miso), .SCLK(sclk0), .MOSI(mosi0),
        .SS_n(ss0), .busy(busy0), .done(done0), .rd_data(rd0)
    );

    spi_mnrch_param #(.DATA_W(8), .SCLK_DIV(4), .NUM_SS(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .wrt(wrt1), .wt_data(wd1), .ss_sel(sel1),
        .cpol(cpol1), .cpha(cpha1), .MISO(miso), .SCLK(sclk1), .MOSI(mosi1),
        .SS_n(ss1), .busy(busy1), .done(done1), .rd_data(rd1)
    );

    typedef struct {
        logic [31:0] rd;
        logic [15:0] mosi;
        int          cyc;
        logic        pol;
        bit          serf;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          pol;
        bit          pha;
        logic [15:0] wd;
        logic [15:0] sw;
    } vec_t;

    int errors = 0, checks = 0;

    // serf / monitor state
    bit          act = 1'b0;          // 0: dut0, 1: dut1 (serf on SS_n[2])
    logic [15:0] serf_word = '0;
    logic        s_cpol = 1'b1, s_cpha = 1'b1;
    logic [15:0] s_tx, s_rx;
    int          s_bit, s_lead, s_trail, hi_cnt, last_gap, ndone, w;
    logic        s_ss_p, s_sclk_p, m_ss, m_sclk, m_mosi, done0_p, done1_p;
    bit          other_low, ss0_low_seen;
    exp_t        em;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Serf model and scoreboard consumer, sampled 1 time unit after each edge.
    initial begin
        serf_miso = 1'b0; s_tx = '0; s_rx = '0; s_bit = 0; s_lead = 0; s_trail = 0;
        hi_cnt = 0; last_gap = 0; ndone = 0; s_ss_p = 1'b1; s_sclk_p = 1'b1;
        done0_p = 1'b0; done1_p = 1'b0; other_low = 1'b0; ss0_low_seen = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_ss   = act ? ss1[2] : ss0[0];
            m_sclk = act ? sclk1 : sclk0;
            m_mosi = act ? mosi1 : mosi0;
            w      = act ? D1 : D0;
            if (!m_ss && s_ss_p) begin
                s_tx = serf_word; s_rx = '0; s_bit = 0; s_lead = 0; s_trail = 0;
                if (!s_cpha) serf_miso = s_tx[w-1];
                last_gap = hi_cnt;
            end else if (!m_ss && (m_sclk != s_sclk_p)) begin
                if (m_sclk != s_cpol) begin
                    s_lead++;
                    if (!s_cpha) s_rx = {s_rx[14:0], m_mosi};
                    else if (s_bit < w) serf_miso = s_tx[w-1-s_bit];
                end else begin
                    s_trail++;
                    if (s_cpha) s_rx = {s_rx[14:0], m_mosi};
                    s_bit++;
                    if (!s_cpha && s_bit < w) serf_miso = s_tx[w-1-s_bit];
                end
            end
            hi_cnt = m_ss ? hi_cnt + 1 : 0;
            if (act && (!ss1[0] || !ss1[1] || !ss1[3])) other_low = 1'b1;
            if (!ss0[0]) ss0_low_seen = 1'b1;
            if (act ? (done1 && !done1_p) : (done0 && !done0_p)) begin
                ndone++;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: done rose with empty scoreboard at cycle %0d", cyc);
                end else begin
                    em = sb.pop_front();
                    chk("rd_data", act ? {24'b0, rd1} : {16'b0, rd0}, em.rd);
                    chk("done_cycle", cyc, em.cyc);
                    chk("busy_at_done", 32'(act ? busy1 : busy0), 32'd0);
                    chk("ss_at_done", 32'(m_ss), 32'd1);
                    chk("sclk_idle_after", 32'(m_sclk), 32'(em.pol));
                    if (em.serf) begin
                        chk("mosi_word", 32'(s_rx), 32'(em.mosi));
                        chk("lead_edges", s_lead, w);
                        chk("trail_edges", s_trail, w);
                    end
                end
            end
            done0_p = done0; done1_p = done1;
            s_ss_p = m_ss; s_sclk_p = m_sclk;
        end
    end

    // Drive one request (wrt left high) and optionally queue its expectation.
    task automatic start(input bit d, input logic [15:0] wd, input logic [1:0] sel,
                         input bit pol, input bit pha, input logic [15:0] sw,
                         input logic [15:0] exp_rd, input bit push, input bit serf);
        exp_t e;
        @(posedge clk); #3;
        act = d; serf_word = sw; s_cpol = pol; s_cpha = pha;
        if (d) begin wd1 = wd[7:0]; sel1 = sel; cpol1 = pol; cpha1 = pha; wrt1 = 1'b1; end
        else   begin wd0 = wd; sel0 = sel[0]; cpol0 = pol; cpha0 = pha; wrt0 = 1'b1; end
        if (push) begin
            e.rd   = d ? {24'b0, exp_rd[7:0]} : {16'b0, exp_rd};
            e.mosi = d ? {8'b0, wd[7:0]} : wd;
            e.cyc  = d ? cyc + 1 + (2*D1+1)*H1 : cyc + 1 + (2*D0+1)*H0;
            e.pol  = pol;
            e.serf = serf;
            sb.push_back(e);
        end
    endtask

    // Single-cycle request, then check the first FRONT cycle.
    task automatic begin_xfer(input bit d, input logic [15:0] wd, input logic [1:0] sel,
                              input bit pol, input bit pha, input logic [15:0] sw,
                              input logic [15:0] exp_rd, input bit push, input bit serf);
        logic [31:0] exp_ss;
        start(d, wd, sel, pol, pha, sw, exp_rd, push, serf);
        @(posedge clk); #3;
        wrt0 = 1'b0; wrt1 = 1'b0;
        exp_ss = d ? 32'(4'hF & ~(4'h1 << sel)) : ((sel == 2'd0) ? 32'd0 : 32'd1);
        chk("busy_front", 32'(d ? busy1 : busy0), 32'd1);
        chk("done_clr", 32'(d ? done1 : done0), 32'd0);
        chk("sclk_idle_front", 32'(d ? sclk1 : sclk0), 32'(pol));
        chk("ss_front", d ? 32'(ss1) : 32'(ss0), exp_ss);
    endtask

    task automatic wait_done(input int limit);
        int n0, k;
        n0 = ndone; k = 0;
        while (ndone == n0 && k < limit) begin @(posedge clk); #3; k++; end
        if (ndone == n0) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done within %0d cycles", limit);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[5];
        exp_t e;
        int   n;
        vt[0] = '{1'b1, 1'b1, 16'hA5C3, 16'h3C5A};
        vt[1] = '{1'b0, 1'b0, 16'h8001, 16'h1234};
        vt[2] = '{1'b0, 1'b1, 16'h8001, 16'hBEEF};
        vt[3] = '{1'b1, 1'b0, 16'h8001, 16'h8001};
        vt[4] = '{1'b1, 1'b1, 16'h8001, 16'h7FFE};

        wrt0 = 0; cpol0 = 0; cpha0 = 0; wd0 = '0; sel0 = '0;
        wrt1 = 0; cpol1 = 0; cpha1 = 0; wd1 = '0; sel1 = '0;
        force_en = 0; force_val = 0;

        // reset values
        repeat (3) @(posedge clk);
        #3;
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_rd", 32'(rd0), 32'd0);
        chk("rst_mosi", 32'(mosi0), 32'd0);
        chk("rst_ss", 32'(ss0), 32'd1);
        chk("rst_sclk", 32'(sclk0), 32'd1);
        chk("rst_ss_alt", 32'(ss1), 32'hF);
        chk("rst_sclk_alt", 32'(sclk1), 32'd1);
        rst_n = 1'b1;

        // default mode 3 and mode sweep
        for (int i = 0; i < 5; i++) begin
            begin_xfer(1'b0, vt[i].wd, 2'd0, vt[i].pol, vt[i].pha, vt[i].sw, vt[i].sw, 1'b1, 1'b1);
            wait_done(400);
        end

        // alternate parameters, serf on select 2
        other_low = 1'b0;
        begin_xfer(1'b1, 16'h005A, 2'd2, 1'b1, 1'b1, 16'h00C3, 16'h00C3, 1'b1, 1'b1);
        wait_done(60);
        begin_xfer(1'b1, 16'h00A7, 2'd2, 1'b0, 1'b0, 16'h003D, 16'h003D, 1'b1, 1'b1);
        wait_done(60);
        chk("alt_other_ss_low", 32'(other_low), 32'd0);

        // out-of-range select: no select asserted, MISO forced high
        force_en = 1'b1; force_val = 1'b1; ss0_low_seen = 1'b0;
        begin_xfer(1'b0, 16'h1357, 2'd1, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
        wait_done(400);
        chk("oor_ss_low", 32'(ss0_low_seen), 32'd0);
        force_en = 1'b0;

        // request and input changes mid-transfer are ignored
        begin_xfer(1'b0, 16'hC0DE, 2'd0, 1'b1, 1'b1, 16'h5AA5, 16'h5AA5, 1'b1, 1'b1);
        n = ndone;
        repeat (50) @(posedge clk);
        #3; wrt0 = 1'b1; wd0 = 16'hFFFF; cpol0 = 1'b0; cpha0 = 1'b0;
        @(posedge clk); #3; wrt0 = 1'b0;
        wait_done(400);
        repeat (300) @(posedge clk);
        #3;
        chk("ignored_single", ndone - n, 1);
        chk("ignored_idle", 32'(busy0), 32'd0);

        // back-to-back with wrt held high
        start(1'b0, 16'h1111, 2'd0, 1'b1, 1'b1, 16'hCAFE, 16'hCAFE, 1'b1, 1'b1);
        n = cyc;
        @(posedge clk); #3;
        wd0 = 16'h2468; serf_word = 16'h9753;
        e.rd = 32'h9753; e.mosi = 16'h2468; e.cyc = n + 2*(1 + (2*D0+1)*H0);
        e.pol = 1'b1; e.serf = 1'b1;
        sb.push_back(e);
        repeat (1 + (2*D0+1)*H0) @(posedge clk);
        #3; wrt0 = 1'b0;
        chk("b2b_done_clr", 32'(done0), 32'd0);
        chk("b2b_busy", 32'(busy0), 32'd1);
        wait_done(400);
        chk("b2b_gap", last_gap, 1);

        // asynchronous reset mid-transfer (mode 0 so SCLK must jump high)
        begin_xfer(1'b0, 16'hF00F, 2'd0, 1'b0, 1'b0, 16'h0F0F, 16'h0000, 1'b0, 1'b1);
        repeat (99) @(posedge clk);
        #3; rst_n = 1'b0;
        #1;
        chk("arst_ss", 32'(ss0), 32'd1);
        chk("arst_sclk", 32'(sclk0), 32'd1);
        chk("arst_busy", 32'(busy0), 32'd0);
        chk("arst_done", 32'(done0), 32'd0);
        chk("arst_rd", 32'(rd0), 32'd0);
        chk("arst_mosi", 32'(mosi0), 32'd0);
        @(posedge clk); #3; rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        chk("arst_no_done", 32'(done0), 32'd0);
        begin_xfer(1'b0, 16'h6C6C, 2'd0, 1'b1, 1'b1, 16'hA1B2, 16'hA1B2, 1'b1, 1'b1);
        wait_done(400);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
